// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch sequencer feeding a UART transmitter: one tx_start pulse per frame, gated by tx_busy.
// Optional sticky write-while-full detection is built when UART_TX_FIFO_OVERFLOW_EN is defined.
module uart_tx_fifo #(
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_CNT    = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      TIMEOUT_LOAD = 8'(BUSY_TIMEOUT);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  state_t            state;
  logic [7:0]        timer;
  logic              push;
  logic              pop;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign wr_ready = !full;
  // No write-through: a full FIFO rejects writes even on a cycle that also pops.
  assign push     = wr_valid && !full;
  assign pop      = (state == IDLE) && !empty && !tx_busy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A launched byte is consumed even if the transmitter never acknowledges it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      timer    <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_start <= 1'b1;
            tx_data  <= mem[rd_ptr];
            timer    <= TIMEOUT_LOAD;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else begin
            timer <= timer - 1'b1;
            if (timer == 8'd1) begin
              state <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_valid && full) begin
      overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios then random traffic, all checked against a queue-based model.
module tb_uart_tx_fifo;

  localparam int DEPTH        = 8;
  localparam int ADDR_W       = 3;
  localparam int BUSY_TIMEOUT = 4;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .count(count),
    .empty(empty),
    .full(full),
    .overflow(overflow)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: a byte queue plus the launch phase (0 idle, 1 awaiting busy, 2 frame running).
  logic [7:0] mdl_q[$];
  int         mdl_phase;
  int         mdl_timer;
  bit         mdl_start;
  logic [7:0] mdl_data;
  bit         mdl_ovf;
  bit         prev_start;

  logic [7:0] launch_log[$];
  logic [7:0] fill_bytes[8];
  int         tx_pend;
  int         tx_frame;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    mdl_q.delete();
    mdl_phase  = 0;
    mdl_timer  = 0;
    mdl_start  = 1'b0;
    mdl_data   = 8'h00;
    mdl_ovf    = 1'b0;
    prev_start = 1'b0;
  endtask

  task automatic modelEdge();
    bit is_full;
    bit launch;
    is_full = (mdl_q.size() == DEPTH);
    launch  = (mdl_phase == 0) && (mdl_q.size() != 0) && !tx_busy;
    if (OVF_EN && wr_valid && is_full) mdl_ovf = 1'b1;
    mdl_start = launch;
    if (launch) begin
      mdl_data  = mdl_q.pop_front();
      mdl_phase = 1;
      mdl_timer = BUSY_TIMEOUT;
    end else if (mdl_phase == 1) begin
      if (tx_busy) mdl_phase = 2;
      else begin
        mdl_timer--;
        if (mdl_timer == 0) mdl_phase = 0;
      end
    end else if (mdl_phase == 2 && !tx_busy) begin
      mdl_phase = 0;
    end
    if (wr_valid && !is_full) mdl_q.push_back(wr_data);
  endtask

  task automatic checkOutput();
    check("tx_start", tx_start, mdl_start);
    check("tx_data", tx_data, mdl_data);
    check("count", count, mdl_q.size());
    check("empty", empty, mdl_q.size() == 0);
    check("full", full, mdl_q.size() == DEPTH);
    check("wr_ready", wr_ready, mdl_q.size() != DEPTH);
    check("overflow", overflow, mdl_ovf);
    check("no_back_to_back", prev_start && tx_start, 1'b0);
    prev_start = tx_start;
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Transmitter stand-in: busy rises dly cycles after each tx_start (0 = never) for frame cycles (0 = random).
  task automatic applyStimulus(input int cycles, input int dly, input int frame, input bit rand_wr);
    for (int i = 0; i < cycles; i++) begin
      if (rand_wr) begin
        wr_valid = ($urandom_range(0, 9) < 6);
        wr_data  = 8'($urandom);
      end
      if (tx_pend > 0) begin
        tx_pend--;
        if (tx_pend == 0) tx_frame = (frame > 0) ? frame : int'($urandom_range(1, 8));
      end
      tx_busy = (tx_frame > 0);
      if (tx_frame > 0) tx_frame--;
      tick();
      if (tx_start) begin
        launch_log.push_back(tx_data);
        tx_pend = (dly >= 0) ? dly : int'($urandom_range(0, 6));
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    tx_busy  = 1'b0;
    tx_pend  = 0;
    tx_frame = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput();
    #2 reset = 1'b0;

    $display("[TB] single byte launch");
    wr_valid = 1'b1;
    wr_data  = 8'h67;
    tick();
    check("t1_no_start_on_accept", tx_start, 1'b0);
    wr_valid = 1'b0;
    tick();
    check("t1_start_next_cycle", tx_start, 1'b1);
    check("t1_data", tx_data, 8'h67);
    repeat (3) tick();
    tx_busy = 1'b1;
    repeat (10) tick();
    tx_busy = 1'b0;
    tick();
    check("t1_count_drained", count, 0);

    $display("[TB] queue behind busy transmitter");
    tx_busy  = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hA5; tick();
    wr_data  = 8'h3C; tick();
    wr_data  = 8'hF0; tick();
    wr_valid = 1'b0;
    tick();
    check("t2_count", count, 3);
    check("t2_held", tx_start, 1'b0);
    launch_log.delete();
    applyStimulus(50, 1, 10, 1'b0);
    check("t2_launches", launch_log.size(), 3);
    if (launch_log.size() == 3) begin
      check("t2_first", launch_log[0], 8'hA5);
      check("t2_second", launch_log[1], 8'h3C);
      check("t2_third", launch_log[2], 8'hF0);
    end

    $display("[TB] fill, overflow and drain");
    tx_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      tick();
    end
    wr_data = 8'hFF;
    tick();
    wr_valid = 1'b0;
    check("t3_full", full, 1'b1);
    check("t3_wr_ready", wr_ready, 1'b0);
    check("t3_count", count, DEPTH);
    check("t3_overflow", overflow, OVF_EN);
    launch_log.delete();
    applyStimulus(80, 1, 3, 1'b0);
    check("t3_launches", launch_log.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < launch_log.size(); i++) check("t3_order", launch_log[i], i);

    tx_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      fill_bytes[i] = 8'($urandom);
      wr_valid = 1'b1;
      wr_data  = fill_bytes[i];
      tick();
    end
    wr_valid = 1'b0;
    launch_log.delete();
    applyStimulus(80, 1, 3, 1'b0);
    check("t3_refill_launches", launch_log.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < launch_log.size(); i++) check("t3_refill_order", launch_log[i], fill_bytes[i]);

    $display("[TB] busy timeout");
    tx_busy  = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h11; tick();
    wr_data  = 8'h22; tick();
    wr_valid = 1'b0;
    launch_log.delete();
    applyStimulus(20, 0, 1, 1'b0);
    check("t4_launches", launch_log.size(), 2);
    if (launch_log.size() == 2) begin
      check("t4_first", launch_log[0], 8'h11);
      check("t4_second", launch_log[1], 8'h22);
    end

    $display("[TB] write while full during pop");
    tx_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      tick();
    end
    wr_data = 8'hEE;
    tx_busy = 1'b0;
    tick();
    wr_valid = 1'b0;
    check("t5_count", count, DEPTH - 1);
    check("t5_start", tx_start, 1'b1);
    applyStimulus(80, 1, 3, 1'b0);

    $display("[TB] reset during frame");
    tx_busy  = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    tx_busy  = 1'b1;
    tick();
    check("t6_count_before", count, 2);
    #3 reset = 1'b1;
    #1;
    modelReset();
    checkOutput();
    check("t6_async_count", count, 0);
    check("t6_async_start", tx_start, 1'b0);
    #2 reset = 1'b0;
    tx_busy  = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    tick();
    wr_valid = 1'b0;
    tick();
    check("t6_relaunch_start", tx_start, 1'b1);
    check("t6_relaunch_data", tx_data, 8'h5A);
    applyStimulus(20, 1, 3, 1'b0);

    $display("[TB] random traffic");
    applyStimulus(600, -1, 0, 1'b1);
    wr_valid = 1'b0;
    applyStimulus(150, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
